z80fi_collector: RTL and testbench

Z80FI_COLLECTOR -- requirements
Module: z80fi_collector

---
 rtl/z80fi_collector_pkg.sv | 57 +++++
 rtl/z80fi_tcount.sv | 29 ++
 rtl/z80fi_collector.sv | 137 +++++++++++++
 tb/tb_z80fi_collector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_collector_pkg.sv
// rtl/z80fi_collector_pkg.sv - shared M-cycle codes, record field widths and record helpers
package z80fi_collector_pkg;

    typedef enum logic [2:0] {
        CYCLE_NONE     = 3'd0,
        CYCLE_M1       = 3'd1,
        CYCLE_RDWR_MEM = 3'd2,
        CYCLE_RDWR_IO  = 3'd3,
        CYCLE_INTERNAL = 3'd4,
        CYCLE_INTACK   = 3'd5
    } cycle_t;

    localparam int INSN_W      = 32;
    localparam int INSN_LEN_W  = 3;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int CYCLE_W     = 3;
    localparam int MAX_BYTES   = 4;
    localparam int MAX_MCYCLES = 4;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // mcnt counts opened M-cycles 1..5; 5 means the record has spilled past slot 4
    typedef struct packed {
        logic [INSN_W-1:0]                      insn;
        logic [INSN_LEN_W-1:0]                  len;
        logic [ADDR_W-1:0]                      ip_in;
        logic [ADDR_W-1:0]                      raddr;
        logic [DATA_W-1:0]                      rdata;
        logic                                   rd_seen;
        logic [2:0]                             mcnt;
        logic [MAX_MCYCLES-1:0][CYCLE_W-1:0]    types;
    } rec_t;

    function automatic rec_t apply_data(
        input rec_t              r,
        input logic              byte_valid,
        input logic [DATA_W-1:0] byte_data,
        input logic              rd_valid,
        input logic [ADDR_W-1:0] rd_addr,
        input logic [DATA_W-1:0] rd_data
    );
        rec_t o;
        o = r;
        if (byte_valid && r.len < INSN_LEN_W'(MAX_BYTES)) begin
            o.insn[{r.len[1:0], 3'b000} +: 8] = byte_data;
            o.len = r.len + 3'd1;
        end
        if (rd_valid && !r.rd_seen) begin
            o.raddr   = rd_addr;
            o.rdata   = rd_data;
            o.rd_seen = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/z80fi_tcount.sv
// rtl/z80fi_tcount.sv - saturating per-slot T-cycle counter with clear, load-1 and increment
module z80fi_tcount #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_inc
);

    // count_inc is exposed so a record closing this cycle can publish the value before it lands
    assign count_inc = (count == {W{1'b1}}) ? count : count + W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= W'(1);
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/z80fi_collector.sv
// rtl/z80fi_collector.sv - gathers per-instruction Z80 bus activity into one published record
module z80fi_collector
    import z80fi_collector_pkg::*;
#(
    parameter int TCYCLE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mcycle_start,
    input  logic [CYCLE_W-1:0]    mcycle_type,
    input  logic                  insn_done,
    input  logic [ADDR_W-1:0]     ip,
    input  logic                  insn_byte_valid,
    input  logic [DATA_W-1:0]     insn_byte,
    input  logic                  mem_rd_valid,
    input  logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  z80fi_valid,
    output logic [INSN_W-1:0]     z80fi_insn,
    output logic [INSN_LEN_W-1:0] z80fi_insn_len,
    output logic [ADDR_W-1:0]     z80fi_reg_ip_in,
    output logic [ADDR_W-1:0]     z80fi_bus_raddr,
    output logic [DATA_W-1:0]     z80fi_bus_rdata,
    output logic [CYCLE_W-1:0]    z80fi_mcycle_type1,
    output logic [CYCLE_W-1:0]    z80fi_mcycle_type2,
    output logic [CYCLE_W-1:0]    z80fi_mcycle_type3,
    output logic [CYCLE_W-1:0]    z80fi_mcycle_type4,
    output logic [TCYCLE_W-1:0]   z80fi_tcycles1,
    output logic [TCYCLE_W-1:0]   z80fi_tcycles2,
    output logic [TCYCLE_W-1:0]   z80fi_tcycles3,
    output logic [TCYCLE_W-1:0]   z80fi_tcycles4,
    output logic                  z80fi_overflow
);

    state_t state;
    rec_t   wrk, upd, fresh, nxt;
    logic   active, open_rec, old_start, publish, ovf_evt;

    logic [MAX_MCYCLES-1:0] t_load, t_clear, t_inc;
    logic [TCYCLE_W-1:0]    t_count     [MAX_MCYCLES];
    logic [TCYCLE_W-1:0]    t_count_inc [MAX_MCYCLES];
    logic [TCYCLE_W-1:0]    t_pub       [MAX_MCYCLES];

    // upd: the open record with this T-cycle applied; fresh: a record opened on this edge
    always_comb begin
        active    = (state == ST_ACTIVE);
        open_rec  = mcycle_start && (mcycle_type == CYCLE_M1) && (!active || insn_done);
        old_start = active && mcycle_start && !open_rec;
        publish   = active && insn_done;
        ovf_evt   = 1'b0;
        upd       = wrk;
        if (active && !open_rec) begin
            if (mcycle_start) begin
                if (wrk.mcnt < 3'(MAX_MCYCLES)) begin
                    upd.types[wrk.mcnt[1:0]] = mcycle_type;
                end else begin
                    ovf_evt = 1'b1;
                end
                if (wrk.mcnt < 3'd5) begin
                    upd.mcnt = wrk.mcnt + 3'd1;
                end
            end
            if (insn_byte_valid && wrk.len == INSN_LEN_W'(MAX_BYTES)) begin
                ovf_evt = 1'b1;
            end
            upd = apply_data(upd, insn_byte_valid, insn_byte, mem_rd_valid, mem_rd_addr, mem_rd_data);
        end
        fresh          = '0;
        fresh.ip_in    = ip;
        fresh.types[0] = CYCLE_M1;
        fresh.mcnt     = 3'd1;
        fresh          = apply_data(fresh, insn_byte_valid, insn_byte, mem_rd_valid, mem_rd_addr, mem_rd_data);
        nxt            = open_rec ? fresh : upd;
    end

    for (genvar i = 0; i < MAX_MCYCLES; i++) begin : g_slot
        assign t_load[i]  = ((i == 0) && open_rec) || (old_start && wrk.mcnt == 3'(i));
        assign t_clear[i] = (i != 0) && open_rec;
        assign t_inc[i]   = active && !mcycle_start && wrk.mcnt == 3'(i + 1);
        assign t_pub[i]   = t_inc[i] ? t_count_inc[i] : t_count[i];

        z80fi_tcount #(.W(TCYCLE_W)) u_tcount (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (t_clear[i]),
            .load      (t_load[i]),
            .inc       (t_inc[i]),
            .count     (t_count[i]),
            .count_inc (t_count_inc[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            wrk                <= '0;
            z80fi_valid        <= 1'b0;
            z80fi_overflow     <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_reg_ip_in    <= '0;
            z80fi_bus_raddr    <= '0;
            z80fi_bus_rdata    <= '0;
            z80fi_mcycle_type1 <= CYCLE_NONE;
            z80fi_mcycle_type2 <= CYCLE_NONE;
            z80fi_mcycle_type3 <= CYCLE_NONE;
            z80fi_mcycle_type4 <= CYCLE_NONE;
            z80fi_tcycles1     <= '0;
            z80fi_tcycles2     <= '0;
            z80fi_tcycles3     <= '0;
            z80fi_tcycles4     <= '0;
        end else begin
            state       <= open_rec ? ST_ACTIVE : (publish ? ST_IDLE : state);
            wrk         <= nxt;
            z80fi_valid <= publish;
            if (ovf_evt) begin
                z80fi_overflow <= 1'b1;
            end
            if (publish) begin
                z80fi_insn         <= upd.insn;
                z80fi_insn_len     <= upd.len;
                z80fi_reg_ip_in    <= upd.ip_in;
                z80fi_bus_raddr    <= upd.raddr;
                z80fi_bus_rdata    <= upd.rdata;
                z80fi_mcycle_type1 <= upd.types[0];
                z80fi_mcycle_type2 <= upd.types[1];
                z80fi_mcycle_type3 <= upd.types[2];
                z80fi_mcycle_type4 <= upd.types[3];
                z80fi_tcycles1     <= t_pub[0];
                z80fi_tcycles2     <= t_pub[1];
                z80fi_tcycles3     <= t_pub[2];
                z80fi_tcycles4     <= t_pub[3];
            end
        end
    end

endmodule

// File: tb/tb_z80fi_collector.sv
// tb/tb_z80fi_collector.sv - scoreboard bench for z80fi_collector
module tb_z80fi_collector;
    import z80fi_collector_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mcycle_start;
    logic [2:0]  mcycle_type;
    logic        insn_done;
    logic [15:0] ip;
    logic        insn_byte_valid;
    logic [7:0]  insn_byte;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_reg_ip_in, z80fi_bus_raddr;
    logic [7:0]  z80fi_bus_rdata;
    logic [2:0]  z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4;
    logic [3:0]  z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4;
    logic        z80fi_overflow;

    z80fi_collector #(.TCYCLE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .mcycle_start(mcycle_start), .mcycle_type(mcycle_type),
        .insn_done(insn_done), .ip(ip), .insn_byte_valid(insn_byte_valid), .insn_byte(insn_byte),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_bus_raddr(z80fi_bus_raddr),
        .z80fi_bus_rdata(z80fi_bus_rdata),
        .z80fi_mcycle_type1(z80fi_mcycle_type1), .z80fi_mcycle_type2(z80fi_mcycle_type2),
        .z80fi_mcycle_type3(z80fi_mcycle_type3), .z80fi_mcycle_type4(z80fi_mcycle_type4),
        .z80fi_tcycles1(z80fi_tcycles1), .z80fi_tcycles2(z80fi_tcycles2),
        .z80fi_tcycles3(z80fi_tcycles3), .z80fi_tcycles4(z80fi_tcycles4),
        .z80fi_overflow(z80fi_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      insn;
        logic [2:0]       len;
        logic [15:0]      ip;
        logic [15:0]      raddr;
        logic [7:0]       rdata;
        logic [3:0][2:0]  ty;
        logic [3:0][3:0]  tc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   pulse_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] insn, input logic [2:0] len, input logic [15:0] a,
                            input logic [15:0] raddr, input logic [7:0] rdata,
                            input logic [11:0] ty, input logic [15:0] tc, input logic ovf);
        exp_t e;
        e.insn = insn; e.len = len; e.ip = a; e.raddr = raddr; e.rdata = rdata;
        e.ty = ty; e.tc = tc; e.ovf = ovf;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && z80fi_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                pulse_cyc.push_back(cyc);
                check_val("insn",     z80fi_insn, got_e.insn);
                check_val("len",      32'(z80fi_insn_len), 32'(got_e.len));
                check_val("ip_in",    32'(z80fi_reg_ip_in), 32'(got_e.ip));
                check_val("raddr",    32'(z80fi_bus_raddr), 32'(got_e.raddr));
                check_val("rdata",    32'(z80fi_bus_rdata), 32'(got_e.rdata));
                check_val("type1",    32'(z80fi_mcycle_type1), 32'(got_e.ty[0]));
                check_val("type2",    32'(z80fi_mcycle_type2), 32'(got_e.ty[1]));
                check_val("type3",    32'(z80fi_mcycle_type3), 32'(got_e.ty[2]));
                check_val("type4",    32'(z80fi_mcycle_type4), 32'(got_e.ty[3]));
                check_val("tcycles1", 32'(z80fi_tcycles1), 32'(got_e.tc[0]));
                check_val("tcycles2", 32'(z80fi_tcycles2), 32'(got_e.tc[1]));
                check_val("tcycles3", 32'(z80fi_tcycles3), 32'(got_e.tc[2]));
                check_val("tcycles4", 32'(z80fi_tcycles4), 32'(got_e.tc[3]));
                check_val("overflow", 32'(z80fi_overflow), 32'(got_e.ovf));
            end
        end
    end

    task automatic clear_inputs();
        mcycle_start = 1'b0; mcycle_type = CYCLE_NONE; insn_done = 1'b0;
        insn_byte_valid = 1'b0; insn_byte = 8'h00;
        mem_rd_valid = 1'b0; mem_rd_addr = 16'h0000; mem_rd_data = 8'h00;
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            clear_inputs();
        end
    endtask

    task automatic start(input logic [2:0] t);
        mcycle_start = 1'b1; mcycle_type = t;
    endtask

    task automatic ibyte(input logic [7:0] b);
        insn_byte_valid = 1'b1; insn_byte = b;
    endtask

    task automatic mread(input logic [15:0] a, input logic [7:0] d);
        mem_rd_valid = 1'b1; mem_rd_addr = a; mem_rd_data = d;
    endtask

    localparam logic [11:0] TY_M1 = {3'(CYCLE_NONE), 3'(CYCLE_NONE), 3'(CYCLE_NONE), 3'(CYCLE_M1)};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        ip = 16'h0000;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid",    32'(z80fi_valid), 32'd0);
        check_val("rst_overflow", 32'(z80fi_overflow), 32'd0);
        check_val("rst_insn",     z80fi_insn, 32'd0);
        check_val("rst_len",      32'(z80fi_insn_len), 32'd0);
        check_val("rst_type1",    32'(z80fi_mcycle_type1), 32'(CYCLE_NONE));
        check_val("rst_tcycles1", 32'(z80fi_tcycles1), 32'd0);
        reset_n = 1'b1;
        step(2);

        // DJNZ taken: M1 5T, displacement read 3T, internal 5T
        push_exp(32'h10, 3'd1, 16'h0100, 16'h0101, 8'hFE,
                 {3'(CYCLE_NONE), 3'(CYCLE_INTERNAL), 3'(CYCLE_RDWR_MEM), 3'(CYCLE_M1)},
                 {4'd0, 4'd5, 4'd3, 4'd5}, 1'b0);
        ip = 16'h0100; start(CYCLE_M1); step();
        ibyte(8'h10); step(); step(3);
        start(CYCLE_RDWR_MEM); step(); step();
        mread(16'h0101, 8'hFE); step();
        start(CYCLE_INTERNAL); step(); step(3);
        insn_done = 1'b1; step();
        step(2);

        // insn_done and stray bus activity while idle
        insn_done = 1'b1; step();
        ibyte(8'h55); mread(16'h7777, 8'h33); insn_done = 1'b1; step();
        step(2);
        check_val("idle_insn",     z80fi_insn, 32'h10);
        check_val("idle_tcycles1", 32'(z80fi_tcycles1), 32'd5);
        check_val("idle_ip_in",    32'(z80fi_reg_ip_in), 32'h0100);

        // back-to-back NOPs with insn_done on the next M1 start
        pulse_cyc.delete();
        push_exp(32'h0, 3'd1, 16'h0000, 16'h0, 8'h0, TY_M1, 16'h0004, 1'b0);
        push_exp(32'h0, 3'd1, 16'h0001, 16'h0, 8'h0, TY_M1, 16'h0004, 1'b0);
        push_exp(32'h0, 3'd1, 16'h0002, 16'h0, 8'h0, TY_M1, 16'h0004, 1'b0);
        ip = 16'h0000; start(CYCLE_M1); step();
        ibyte(8'h00); step(); step(2);
        ip = 16'h0001; start(CYCLE_M1); insn_done = 1'b1; step();
        ibyte(8'h00); step(); step(2);
        ip = 16'h0002; start(CYCLE_M1); insn_done = 1'b1; step();
        ibyte(8'h00); step(); step();
        insn_done = 1'b1; step();
        step(2);
        check_val("nop_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() >= 2)
            check_val("nop_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);

        // 20-clock M1 saturates the T-count
        push_exp(32'h76, 3'd1, 16'h0500, 16'h0, 8'h0, TY_M1, 16'h000F, 1'b0);
        ip = 16'h0500; start(CYCLE_M1); step();
        ibyte(8'h76); step(); step(17);
        insn_done = 1'b1; step();
        step(2);

        // reset mid-DJNZ, leftover activity ignored, then a clean NOP
        ip = 16'h0300; start(CYCLE_M1); step();
        ibyte(8'h10); step(); step();
        reset_n = 1'b0;
        #1;
        check_val("midrst_insn",  z80fi_insn, 32'd0);
        check_val("midrst_valid", 32'(z80fi_valid), 32'd0);
        step();
        reset_n = 1'b1;
        start(CYCLE_RDWR_MEM); step();
        mread(16'h0301, 8'hFE); step();
        insn_done = 1'b1; step();
        push_exp(32'h0, 3'd1, 16'h0400, 16'h0, 8'h0, TY_M1, 16'h0004, 1'b0);
        ip = 16'h0400; start(CYCLE_M1); step();
        ibyte(8'h00); step(); step();
        insn_done = 1'b1; step();
        step(2);

        // five M-cycles and five bytes: slots 1-4 kept, overflow sticky
        push_exp(32'h4605CBDD, 3'd4, 16'h0600, 16'h1234, 8'h5A,
                 {3'(CYCLE_RDWR_MEM), 3'(CYCLE_RDWR_MEM), 3'(CYCLE_M1), 3'(CYCLE_M1)},
                 {4'd3, 4'd3, 4'd4, 4'd4}, 1'b1);
        ip = 16'h0600; start(CYCLE_M1); step();
        ibyte(8'hDD); step(); step(2);
        start(CYCLE_M1); step();
        ibyte(8'hCB); step(); step(2);
        start(CYCLE_RDWR_MEM); step();
        ibyte(8'h05); step();
        mread(16'h1234, 8'h5A); step();
        start(CYCLE_RDWR_MEM); step();
        ibyte(8'h46); step();
        mread(16'h9999, 8'h11); step();
        start(CYCLE_INTERNAL); step();
        ibyte(8'h77); step();
        insn_done = 1'b1; step();
        step(2);
        check_val("ovf_sticky", 32'(z80fi_overflow), 32'd1);
        push_exp(32'h0, 3'd1, 16'h0700, 16'h0, 8'h0, TY_M1, 16'h0004, 1'b1);
        ip = 16'h0700; start(CYCLE_M1); step();
        ibyte(8'h00); step(); step();
        insn_done = 1'b1; step();
        step(3);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
